// File: rtl/instr_encoder_pkg.sv
// Shared RV32I format codes, opcodes and field bundle.
// Used by the encoder and the core decoder alike.
package instr_encoder_pkg;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_OP_IMM = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_OP     = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } fields_t;

    // True when imm[31:msb] are all equal (value fits as signed).
    function automatic logic fits_signed(
        input logic [31:0] imm,
        input int unsigned msb
    );
        logic [31:0] hi;
        hi = $unsigned($signed(imm) >>> msb);
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// Combinational RV32I word assembly with immediate
// range and alignment checking.
import instr_encoder_pkg::*;

module instr_encoder_imm_pack (
    input  fields_t     f_i,
    output logic [31:0] word_o,
    output logic        err_o
);

    logic [31:0] imm;
    assign imm = f_i.imm;

    // Pack fields by format; unknown formats emit a flagged NOP.
    always_comb begin
        word_o = NOP_WORD;
        err_o  = 1'b1;
        case (f_i.fmt)
            FMT_R: begin
                word_o = {f_i.funct7, f_i.rs2, f_i.rs1,
                          f_i.funct3, f_i.rd, f_i.opcode};
                err_o  = 1'b0;
            end
            FMT_I: begin
                word_o = {imm[11:0], f_i.rs1, f_i.funct3,
                          f_i.rd, f_i.opcode};
                err_o  = !fits_signed(imm, 11);
            end
            FMT_S: begin
                word_o = {imm[11:5], f_i.rs2, f_i.rs1,
                          f_i.funct3, imm[4:0], f_i.opcode};
                err_o  = !fits_signed(imm, 11);
            end
            FMT_B: begin
                word_o = {imm[12], imm[10:5], f_i.rs2, f_i.rs1,
                          f_i.funct3, imm[4:1], imm[11],
                          f_i.opcode};
                err_o  = !fits_signed(imm, 12) || imm[0];
            end
            FMT_U: begin
                word_o = {imm[31:12], f_i.rd, f_i.opcode};
                err_o  = |imm[11:0];
            end
            FMT_J: begin
                word_o = {imm[20], imm[10:1], imm[11],
                          imm[19:12], f_i.rd, f_i.opcode};
                err_o  = !fits_signed(imm, 20) || imm[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streams encoded RV32I words with word addresses through
// a single backpressured output register.
import instr_encoder_pkg::*;

module instr_encoder #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_format,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_error,
    output logic              out_last,
    output logic [15:0]       word_count,
    output logic [7:0]        error_count
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    fields_t     fields;
    logic [31:0] enc_word;
    logic        enc_err;
    logic        in_fire;
    logic        out_fire;

    logic              valid_q, valid_d;
    logic [31:0]       word_q, word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [15:0]       wcnt_q, wcnt_d;
    logic [7:0]        ecnt_q, ecnt_d;

    assign fields = '{
        fmt:    in_format,
        opcode: in_opcode,
        rd:     in_rd,
        rs1:    in_rs1,
        rs2:    in_rs2,
        funct3: in_funct3,
        funct7: in_funct7,
        imm:    in_imm
    };

    instr_encoder_imm_pack u_pack (
        .f_i    (fields),
        .word_o (enc_word),
        .err_o  (enc_err)
    );

    assign in_ready = !valid_q || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = valid_q && out_ready;

    // Next state: reload on input, drain on output, restart rebases.
    always_comb begin
        valid_d = valid_q;
        word_d  = word_q;
        addr_d  = addr_q;
        err_d   = err_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        ecnt_d  = ecnt_q;
        if (in_fire) begin
            valid_d = 1'b1;
            word_d  = enc_word;
            addr_d  = restart ? BASE : cnt_q;
            err_d   = enc_err;
            last_d  = in_last;
        end else if (out_fire) begin
            valid_d = 1'b0;
        end
        if (restart) begin
            cnt_d = in_fire ? BASE + 1'b1 : BASE;
        end else if (in_fire) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (restart) begin
            wcnt_d = '0;
            ecnt_d = '0;
        end else if (out_fire) begin
            if (wcnt_q != 16'hFFFF) wcnt_d = wcnt_q + 16'd1;
            if (err_q && ecnt_q != 8'hFF) ecnt_d = ecnt_q + 8'd1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            word_q  <= '0;
            addr_q  <= BASE;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= BASE;
            wcnt_q  <= '0;
            ecnt_q  <= '0;
        end else begin
            valid_q <= valid_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            ecnt_q  <= ecnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_word    = word_q;
    assign out_addr    = addr_q;
    assign out_error   = err_q;
    assign out_last    = last_q;
    assign word_count  = wcnt_q;
    assign error_count = ecnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: default instance plus
// a small-address instance for wrap and restart checks.
import instr_encoder_pkg::*;

module tb_instr_encoder;

    logic        clock, reset, restart;
    logic        in_valid, out_ready, in_last;
    logic [2:0]  in_format, in_funct3;
    logic [6:0]  in_opcode, in_funct7;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;

    logic        a_in_ready, a_out_valid, a_out_error, a_out_last;
    logic [31:0] a_out_word;
    logic [9:0]  a_out_addr;
    logic [15:0] a_word_count;
    logic [7:0]  a_error_count;

    logic        b_in_ready, b_out_valid, b_out_error, b_out_last;
    logic [31:0] b_out_word;
    logic [3:0]  b_out_addr;
    logic [15:0] b_word_count;
    logic [7:0]  b_error_count;

    int n_tests = 0;
    int n_fail  = 0;

    instr_encoder u_dut (
        .clock(clock), .reset(reset), .restart(restart),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .in_format(in_format), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_imm(in_imm), .in_last(in_last),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_word(a_out_word), .out_addr(a_out_addr),
        .out_error(a_out_error), .out_last(a_out_last),
        .word_count(a_word_count), .error_count(a_error_count)
    );

    instr_encoder #(.ADDR_W(4), .BASE_ADDR(14)) u_wrap (
        .clock(clock), .reset(reset), .restart(restart),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_format(in_format), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_imm(in_imm), .in_last(in_last),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_word(b_out_word), .out_addr(b_out_addr),
        .out_error(b_out_error), .out_last(b_out_last),
        .word_count(b_word_count), .error_count(b_error_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic put(input logic [2:0] fmt, input logic [6:0] op,
                       input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm,
                       input logic last);
        in_valid  = 1'b1;
        in_format = fmt;
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
        in_last   = last;
    endtask

    task automatic addi(input logic [4:0] rd, input logic [31:0] imm);
        put(FMT_I, OP_OP_IMM, rd, 5'd0, 5'd0, 3'd0, 7'd0, imm, 1'b0);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        reset = 1'b1; restart = 1'b0; out_ready = 1'b1;
        put(FMT_R, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0);
        idle();
        step(); step();
        reset = 1'b0;
        check("rst_valid", a_out_valid, 0);
        check("rst_word", a_out_word, 0);
        check("rst_addr", a_out_addr, 0);
        check("rst_err", a_out_error, 0);
        check("rst_wcnt", a_word_count, 0);
        check("rst_ecnt", a_error_count, 0);
        check("rst_ready", a_in_ready, 1);
        check("rst_b_addr", b_out_addr, 14);

        addi(5'd1, 32'd5); step();
        check("addi_valid", a_out_valid, 1);
        check("addi_word", a_out_word, 32'h0050_0093);
        check("addi_addr", a_out_addr, 0);
        check("addi_err", a_out_error, 0);
        idle(); step();
        check("addi_drain", a_out_valid, 0);
        check("addi_wcnt", a_word_count, 1);

        restart = 1'b1; step(); restart = 1'b0;
        check("rs_wcnt", a_word_count, 0);

        put(FMT_R, OP_OP, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0, 1'b0);
        step();
        check("sub_word", a_out_word, 32'h4020_81B3);
        check("sub_addr", a_out_addr, 0);
        put(FMT_S, OP_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b0);
        step();
        check("sw_valid", a_out_valid, 1);
        check("sw_word", a_out_word, 32'h0020_A423);
        check("sw_addr", a_out_addr, 1);
        check("sw_wcnt", a_word_count, 1);
        put(FMT_J, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0);
        step();
        check("jal_word", a_out_word, 32'h0010_00EF);
        check("jal_err", a_out_error, 0);
        check("jal_addr", a_out_addr, 2);
        put(FMT_U, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b0);
        step();
        check("lui_word", a_out_word, 32'h1234_52B7);
        check("lui_err", a_out_error, 0);
        put(FMT_B, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b0);
        step();
        check("beq3_err", a_out_error, 1);
        check("beq3_word", a_out_word, 32'h0000_0163);
        addi(5'd1, 32'd2048); step();
        check("addi2048_err", a_out_error, 1);
        check("addi2048_word", a_out_word, 32'h8000_0093);
        put(3'd7, OP_OP, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0, 1'b0);
        step();
        check("ill_word", a_out_word, NOP_WORD);
        check("ill_err", a_out_error, 1);
        check("ill_addr", a_out_addr, 6);
        idle(); step();
        check("err_wcnt", a_word_count, 7);
        check("err_ecnt", a_error_count, 3);

        put(FMT_B, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0, 32'hFFFF_FFFC, 1'b0);
        step();
        check("bne_word", a_out_word, 32'hFE20_9EE3);
        check("bne_err", a_out_error, 0);
        check("bne_addr", a_out_addr, 7);
        put(FMT_U, OP_AUIPC, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 1'b1);
        step();
        check("auipc_word", a_out_word, 32'h1234_5297);
        check("auipc_err", a_out_error, 1);
        check("auipc_last", a_out_last, 1);
        idle(); step();
        check("u_ecnt", a_error_count, 4);
        check("u_wcnt", a_word_count, 9);
        check("u_last_clr", a_out_last, 1);

        out_ready = 1'b0;
        addi(5'd1, 32'd1);
        check("bp_rdy_first", a_in_ready, 1);
        step();
        addi(5'd2, 32'd2);
        check("bp_load", a_out_word, 32'h0010_0093);
        check("bp_rdy0", a_in_ready, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_hold_word", a_out_word, 32'h0010_0093);
            check("bp_hold_addr", a_out_addr, 9);
            check("bp_hold_rdy", a_in_ready, 0);
        end
        out_ready = 1'b1;
        step();
        check("bp_b_word", a_out_word, 32'h0020_0113);
        check("bp_b_addr", a_out_addr, 10);
        check("bp_b_wcnt", a_word_count, 10);
        addi(5'd3, 32'd3); step();
        check("bp_c_word", a_out_word, 32'h0030_0193);
        check("bp_c_addr", a_out_addr, 11);
        idle(); step();
        check("bp_drain", a_out_valid, 0);
        check("bp_wcnt", a_word_count, 12);

        addi(5'd4, 32'd4); step();
        check("d_addr", a_out_addr, 12);
        restart = 1'b1;
        addi(5'd5, 32'd5); step();
        restart = 1'b0;
        check("rsin_word", a_out_word, 32'h0050_0293);
        check("rsin_addr", a_out_addr, 0);
        check("rsout_wcnt", a_word_count, 0);
        addi(5'd6, 32'd6); step();
        check("rsnext_addr", a_out_addr, 1);
        check("rsnext_wcnt", a_word_count, 1);
        idle(); step();

        reset = 1'b1; step(); reset = 1'b0;
        check("w_rst_valid", b_out_valid, 0);
        check("w_rst_ready", b_in_ready, 1);
        addi(5'd4, 32'd4); step();
        check("w_addr14", b_out_addr, 14);
        addi(5'd5, 32'd5); step();
        check("w_addr15", b_out_addr, 15);
        addi(5'd6, 32'd6); step();
        check("w_addr0", b_out_addr, 0);
        check("w_word", b_out_word, 32'h0060_0313);
        idle(); step();
        check("w_wcnt3", b_word_count, 3);
        restart = 1'b1; step(); restart = 1'b0;
        addi(5'd7, 32'd7); step();
        check("w_rs_addr", b_out_addr, 14);
        idle(); step();
        check("w_rs_wcnt", b_word_count, 1);
        addi(5'd8, 32'd8); step();
        check("w_pend", b_out_valid, 1);
        idle();
        reset = 1'b1; step(); reset = 1'b0;
        check("w_mid_valid", b_out_valid, 0);
        check("w_mid_word", b_out_word, 0);
        check("w_mid_addr", b_out_addr, 14);
        check("w_mid_err", b_out_error, 0);
        check("w_mid_last", b_out_last, 0);
        check("w_mid_wcnt", b_word_count, 0);
        check("w_mid_ecnt", b_error_count, 0);
        check("a_mid_valid", a_out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Encodes RV32I instruction fields into 32-bit instruction words and streams them, with a word address, into instruction memory or a boot loader.
- Shares the core's format and immediate layout definitions, so any word it emits decodes back to the same fields.
- Accepts one field bundle per valid/ready handshake.
- Checks immediate range and alignment, and presents a registered word, address and error flag on a backpressured output port.

Parameters:
- ADDR_W, 10, width of the word-address counter.
- BASE_ADDR, 0, word address loaded on reset and on restart.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- restart  in  1  reloads the address counter to BASE_ADDR and clears the counters; no effect on the output register.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle this cycle.
- in_format  in  3  FMT_* code.
- in_opcode  in  7  major opcode.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_funct3  in  3  funct3 field.
- in_funct7  in  7  funct7 field; R format only.
- in_imm  in  32  signed byte offset or immediate; for U format, the full upper value.
- in_last  in  1  marks the final bundle of a program.
- out_valid  out  1  word valid.
- out_ready  in  1  downstream accepts the word.
- out_word  out  32  encoded instruction.
- out_addr  out  ADDR_W  word address of out_word.
- out_error  out  1  range, alignment or format error on this word.
- out_last  out  1  copy of in_last.
- word_count  out  16  words accepted downstream since reset/restart; saturates at 0xFFFF.
- error_count  out  8  errored words accepted downstream; saturates at 0xFF.

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-high.
- Reset values: out_valid=0, out_word=0, out_addr=BASE_ADDR, out_error=0, out_last=0, word_count=0, error_count=0, address counter=BASE_ADDR.
- Output register: one entry.
  - in_ready = !out_valid || out_ready (combinational).
  - Input handshake (in_valid && in_ready) loads the register next edge; latency is 1 cycle.
  - Full throughput when out_ready is held high.
- Output stability: while out_valid && !out_ready, out_word/out_addr/out_error/out_last hold stable.
- Address: out_addr takes the counter value at load time; the counter increments on each input handshake and wraps from 2^ADDR_W-1 to 0.
- Counters: word_count and error_count update on the output handshake (out_valid && out_ready).
- Word layout per format:
  - FMT_R: funct7, rs2, rs1, funct3, rd, opcode.
  - FMT_I: imm[11:0], rs1, funct3, rd, opcode.
  - FMT_S: imm[11:5], rs2, rs1, funct3, imm[4:0], opcode.
  - FMT_B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode.
  - FMT_U: imm[31:12], rd, opcode.
  - FMT_J: imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode.
- Error rules (out_error=1; word still encoded from the truncated immediate):
  - I/S: imm[31:11] not all equal.
  - B: imm[31:12] not all equal, or imm[0]=1.
  - J: imm[31:20] not all equal, or imm[0]=1.
  - U: imm[11:0] != 0.
  - R: never errors; in_imm is ignored.
- Illegal format (codes 6, 7): out_error=1, out_word=32'h0000_0013 (NOP).
- Simultaneous events:
  - Output handshake and input handshake in the same cycle: register reloads, no bubble.
  - restart coincident with an input handshake: the loaded word gets BASE_ADDR and the counter becomes BASE_ADDR+1.
  - restart coincident with an output handshake: counters become 0; restart wins.
- Reset mid-stream: any pending word is discarded; all outputs return to their reset values next edge.

Decomposition:
- Shared package holds:
  - FMT_R=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_U=4, FMT_J=5;
  - opcode constants OP_OP_IMM, OP_OP, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC;
  - NOP_WORD.
- One natural sub-module: imm_pack, the combinational word assembly and range/alignment check. It is exhaustively testable against the core decoder's field extraction.

Test Plan:
- ADDI x1,x0,5: FMT_I, opcode 0x13, rd=1, rs1=0, f3=0, imm=5, out_ready=1 -> out_word=0x00500093 one cycle later, out_addr=0, out_error=0.
- SUB x3,x1,x2 then SW x2,8(x1) back-to-back:
  - SUB: FMT_R, opcode 0x33, f7=0x20 -> 0x402081B3 at addr 0.
  - SW: FMT_S, opcode 0x23, f3=2 -> 0x0020A423 at addr 1.
  - Both words on consecutive cycles, with no bubble.
- JAL x1,+2048 -> 0x001000EF, error=0.
- Error cases:
  - BEQ with imm=3 -> out_error=1.
  - ADDI with imm=2048 -> out_error=1.
  - Illegal format 7 -> out_word=0x00000013, out_error=1.
  - error_count=3 after all three are accepted.
- Backpressure:
  - Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 from the second cycle on; the first word is held stable.
  - Release -> words emerge in order with no loss or duplication.
- Wrap and restart: ADDR_W=4, BASE_ADDR=14, three words -> addresses 14, 15, 0; restart -> next word at 14, word_count=1; reset while out_valid=1 -> out_valid=0 next cycle.
